// File: rtl/div_pkg.sv
// Shared types and defaults for the programmable clock divider controller.
package div_pkg;

    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } state_t;

endpackage : div_pkg

// File: rtl/div_ctrl_if.sv
// Run request, configuration handshake and waveform outputs of div_ctrl.
interface div_ctrl_if #(
    parameter int CNT_W = div_pkg::CNT_W_DEF
);
    logic             en_sig;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CNT_W-1:0] cfg_num;
    logic [CNT_W-1:0] cfg_duty;
    logic             div_sig;
    logic             period_sig;
    logic             busy_sig;
    logic             err_sig;

    modport master (
        output en_sig, cfg_valid, cfg_num, cfg_duty,
        input  cfg_ready, div_sig, period_sig, busy_sig, err_sig
    );

    modport slave (
        input  en_sig, cfg_valid, cfg_num, cfg_duty,
        output cfg_ready, div_sig, period_sig, busy_sig, err_sig
    );
endinterface : div_ctrl_if

// File: rtl/div_core.sv
// Period counter with duty compare and wrap detect; outputs are registered
// from the next-cycle counter value so they line up with cnt itself.
module div_core #(
    parameter int CNT_W = div_pkg::CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run_now,
    input  logic             run_next,
    input  logic [CNT_W-1:0] num_act,
    input  logic [CNT_W-1:0] num_next,
    input  logic [CNT_W-1:0] duty_next,
    output logic             wrap,
    output logic             div_sig,
    output logic             period_sig
);
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;

    // A ratio of 0 or 1 makes every running cycle the last one of its period.
    assign wrap = run_now &&
                  ((num_act <= CNT_W'(1)) || (cnt == num_act - CNT_W'(1)));

    always_comb begin
        cnt_n = '0;
        if (run_now && !wrap) begin
            cnt_n = cnt + CNT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; the outputs are computed from cnt_n, not cnt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            div_sig    <= 1'b0;
            period_sig <= 1'b0;
        end else begin
            cnt        <= cnt_n;
            div_sig    <= run_next && (cnt_n < duty_next);
            period_sig <= run_next &&
                          ((num_next <= CNT_W'(1)) ||
                           (cnt_n == num_next - CNT_W'(1)));
        end
    end
endmodule : div_core

// File: rtl/div_ctrl.sv
// Divider controller: FSM, config handshake, shadow settings and range check.
// Define DIV_CTRL_ERR_EN to reject out-of-range configs with an err_sig pulse.
module div_ctrl
    import div_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEF,
    parameter int DEF_NUM  = 2,
    parameter int DEF_DUTY = 1
) (
    input  logic      clk_sig,
    input  logic      rst_sig,
    div_ctrl_if.slave bus
);
    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] num_act;
    logic [CNT_W-1:0] duty_act;
    logic [CNT_W-1:0] num_n;
    logic [CNT_W-1:0] duty_n;
    logic [CNT_W-1:0] num_sh;
    logic [CNT_W-1:0] duty_sh;
    logic             cfg_rdy_q;
    logic             busy_q;
    logic             err_q;
    logic             accept;
    logic             cfg_bad;
    logic             take;
    logic             sh_load;
    logic             wrap;
    logic             run_now;
    logic             run_next;
    logic             div_w;
    logic             period_w;

    assign accept = bus.cfg_valid && cfg_rdy_q;

`ifdef DIV_CTRL_ERR_EN
    assign cfg_bad = (bus.cfg_num < CNT_W'(2)) ||
                     (bus.cfg_duty == '0) ||
                     (bus.cfg_duty >= bus.cfg_num);
`else
    assign cfg_bad = 1'b0;
`endif

    assign take    = accept && !cfg_bad;
    assign run_now = (state != ST_IDLE);

    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_n = state;
        num_n   = num_act;
        duty_n  = duty_act;
        sh_load = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (take) begin
                    num_n  = bus.cfg_num;
                    duty_n = bus.cfg_duty;
                end
                if (bus.en_sig) begin
                    state_n = ST_RUN;
                end
            end
            ST_RUN: begin
                // Stopping at this wrap: nothing follows, so a config taken
                // now goes straight to the active settings.
                if (wrap && !bus.en_sig) begin
                    state_n = ST_IDLE;
                    if (take) begin
                        num_n  = bus.cfg_num;
                        duty_n = bus.cfg_duty;
                    end
                end else if (take) begin
                    state_n = ST_PEND;
                    sh_load = 1'b1;
                end
            end
            ST_PEND: begin
                if (wrap) begin
                    num_n   = num_sh;
                    duty_n  = duty_sh;
                    state_n = bus.en_sig ? ST_RUN : ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign run_next = (state_n != ST_IDLE);

    always_ff @(posedge clk_sig or negedge rst_sig) begin
        if (!rst_sig) begin
            state     <= ST_IDLE;
            num_act   <= CNT_W'(DEF_NUM);
            duty_act  <= CNT_W'(DEF_DUTY);
            num_sh    <= CNT_W'(DEF_NUM);
            duty_sh   <= CNT_W'(DEF_DUTY);
            cfg_rdy_q <= 1'b1;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state    <= state_n;
            num_act  <= num_n;
            duty_act <= duty_n;
            if (sh_load) begin
                num_sh  <= bus.cfg_num;
                duty_sh <= bus.cfg_duty;
            end
            cfg_rdy_q <= (state_n != ST_PEND);
            busy_q    <= run_next;
            err_q     <= accept && cfg_bad;
        end
    end

    div_core #(
        .CNT_W (CNT_W)
    ) u_core (
        .clk        (clk_sig),
        .rst_n      (rst_sig),
        .run_now    (run_now),
        .run_next   (run_next),
        .num_act    (num_act),
        .num_next   (num_n),
        .duty_next  (duty_n),
        .wrap       (wrap),
        .div_sig    (div_w),
        .period_sig (period_w)
    );

    assign bus.cfg_ready  = cfg_rdy_q;
    assign bus.busy_sig   = busy_q;
    assign bus.err_sig    = err_q;
    assign bus.div_sig    = div_w;
    assign bus.period_sig = period_w;
endmodule : div_ctrl

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl: a period-level reference model checked every
// cycle, plus literal waveform expectations for the key scenarios.
module tb_div_ctrl;
    localparam int CNT_W = 8;

    logic clk_sig = 1'b0;
    logic rst_sig = 1'b1;
    bit   chk_en  = 1'b0;
    int   n_vec   = 0;
    int   n_bad   = 0;

    div_ctrl_if #(.CNT_W(CNT_W)) bus ();

    div_ctrl #(
        .CNT_W    (CNT_W),
        .DEF_NUM  (2),
        .DEF_DUTY (1)
    ) dut (
        .clk_sig (clk_sig),
        .rst_sig (rst_sig),
        .bus     (bus)
    );

    always #5 clk_sig = ~clk_sig;

    task automatic check(input string name, input logic [31:0] act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: running flag, position in period, active and pending settings.
    bit m_run, m_pend, m_err;
    int m_pos, m_num, m_duty, m_sh_num, m_sh_duty;

    function automatic int plen(input int n);
        return (n <= 1) ? 1 : n;
    endfunction

    task automatic model_step();
        bit accept, bad, take;
        int c_num, c_duty;
        c_num  = int'(bus.cfg_num);
        c_duty = int'(bus.cfg_duty);
        accept = bus.cfg_valid && !m_pend;
        bad    = 1'b0;
`ifdef DIV_CTRL_ERR_EN
        bad = (c_num < 2) || (c_duty < 1) || (c_duty > c_num - 1);
`endif
        m_err = accept && bad;
        take  = accept && !bad;
        if (!m_run) begin
            if (take) begin
                m_num  = c_num;
                m_duty = c_duty;
            end
            if (bus.en_sig) begin
                m_run = 1'b1;
                m_pos = 0;
            end
        end else if (m_pos == plen(m_num) - 1) begin
            m_pos = 0;
            if (m_pend) begin
                m_num  = m_sh_num;
                m_duty = m_sh_duty;
                m_pend = 1'b0;
            end
            if (!bus.en_sig) begin
                m_run = 1'b0;
                if (take) begin
                    m_num  = c_num;
                    m_duty = c_duty;
                end
            end else if (take) begin
                m_sh_num  = c_num;
                m_sh_duty = c_duty;
                m_pend    = 1'b1;
            end
        end else begin
            m_pos++;
            if (take) begin
                m_sh_num  = c_num;
                m_sh_duty = c_duty;
                m_pend    = 1'b1;
            end
        end
    endtask

    always @(posedge clk_sig or negedge rst_sig) begin
        if (!rst_sig) begin
            m_run  = 1'b0;
            m_pend = 1'b0;
            m_err  = 1'b0;
            m_pos  = 0;
            m_num  = 2;
            m_duty = 1;
        end else begin
            model_step();
        end
    end

    always @(negedge clk_sig) begin
        if (chk_en) begin
            check("mdl_div",    bus.div_sig,    (m_run && (m_pos < m_duty)) ? 1 : 0);
            check("mdl_period", bus.period_sig, (m_run && (m_pos == plen(m_num) - 1)) ? 1 : 0);
            check("mdl_busy",   bus.busy_sig,   m_run ? 1 : 0);
            check("mdl_ready",  bus.cfg_ready,  m_pend ? 0 : 1);
            check("mdl_err",    bus.err_sig,    m_err ? 1 : 0);
        end
    end

    task automatic step();
        @(negedge clk_sig);
    endtask

    task automatic offer(input int num, input int duty);
        bus.cfg_valid = 1'b1;
        bus.cfg_num   = CNT_W'(num);
        bus.cfg_duty  = CNT_W'(duty);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_div"},    bus.div_sig,    0);
        check({tag, "_period"}, bus.period_sig, 0);
        check({tag, "_busy"},   bus.busy_sig,   0);
        check({tag, "_err"},    bus.err_sig,    0);
        check({tag, "_ready"},  bus.cfg_ready,  1);
    endtask

`ifdef DIV_CTRL_ERR_EN
    int bad_num[3]  = '{1, 4, 4};
    int bad_duty[3] = '{1, 0, 4};
`endif

    initial begin
        bus.en_sig    = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_num   = '0;
        bus.cfg_duty  = '0;
        #1 rst_sig = 1'b0;
        #1 check_reset_vals("rst");
        step();
        step();
        rst_sig = 1'b1;
        chk_en  = 1'b1;
        step();

        // Defaults 2/1: alternating waveform, period pulse every second cycle.
        bus.en_sig = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("def_div",    bus.div_sig,    (i % 2 == 0) ? 1 : 0);
            check("def_period", bus.period_sig, (i % 2 == 1) ? 1 : 0);
        end

        // Config 5/2 offered at cnt = 0 waits for the wrap.
        step();
        offer(5, 2);
        step();
        bus.cfg_valid = 1'b0;
        check("pend_ready", bus.cfg_ready, 0);
        for (int i = 0; i < 10; i++) begin
            step();
            check("n5_div", bus.div_sig, ((i % 5) < 2) ? 1 : 0);
            if (i == 0) check("n5_ready", bus.cfg_ready, 1);
        end

        // Stop requested at cnt = 1: period runs out to cnt = 4.
        step();
        step();
        bus.en_sig = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stop_busy",   bus.busy_sig,   1);
            check("stop_period", bus.period_sig, (i == 2) ? 1 : 0);
        end
        step();
        check("idle_busy", bus.busy_sig, 0);
        check("idle_div",  bus.div_sig,  0);

        // Config and enable in the same idle cycle govern the first period.
        bus.en_sig = 1'b1;
        offer(3, 1);
        for (int i = 0; i < 6; i++) begin
            step();
            if (i == 0) bus.cfg_valid = 1'b0;
            check("n3_div", bus.div_sig, (i % 3 == 0) ? 1 : 0);
        end

        // Config taken on a wrap cycle applies one period later.
        offer(4, 3);
        step();
        bus.cfg_valid = 1'b0;
        check("wrapcfg_div",   bus.div_sig,   1);
        check("wrapcfg_ready", bus.cfg_ready, 0);
        for (int i = 0; i < 2; i++) begin
            step();
            check("wrapcfg_old", bus.div_sig, 0);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            check("n4_div", bus.div_sig, (i < 3) ? 1 : 0);
        end

        // Stop request withdrawn before the wrap.
        step();
        bus.en_sig = 1'b0;
        step();
        bus.en_sig = 1'b1;
        step();
        step();
        step();
        check("cancel_busy", bus.busy_sig, 1);
        check("cancel_div",  bus.div_sig,  1);

`ifdef DIV_CTRL_ERR_EN
        for (int k = 0; k < 3; k++) begin
            offer(bad_num[k], bad_duty[k]);
            step();
            bus.cfg_valid = 1'b0;
            check("err_pulse", bus.err_sig,   1);
            check("err_ready", bus.cfg_ready, 1);
            step();
            check("err_clear", bus.err_sig, 0);
        end
`else
        // Without the range check a ratio of 1 is loaded as given.
        offer(1, 1);
        step();
        bus.cfg_valid = 1'b0;
        check("n1_ready", bus.cfg_ready, 0);
        step();
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            check("n1_period", bus.period_sig, 1);
            check("n1_div",    bus.div_sig,    1);
        end
`endif

        // Reset during PEND clears outputs without waiting for a clock edge.
        step();
        offer(5, 2);
        step();
        bus.cfg_valid = 1'b0;
        check("prerst_ready", bus.cfg_ready, 0);
        #2 rst_sig = 1'b0;
        #1 check_reset_vals("async");
        step();
        rst_sig = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("postrst_div", bus.div_sig, (i % 2 == 0) ? 1 : 0);
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule : tb_div_ctrl

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 Parameter CNT_W, default 8, width of counter and config fields.
REQ-002 Parameter DEF_NUM, default 2, divide ratio loaded at reset.
REQ-003 Parameter DEF_DUTY, default 1, high-cycle count loaded at reset.
REQ-004 clk_sig  in  1  single clock; all logic on rising edge.
REQ-005 rst_sig  in  1  asynchronous, active-low reset.
REQ-006 en_sig  in  1  run request; level-sensitive.
REQ-007 cfg_valid  in  1  new config offered.
REQ-008 cfg_ready  out  1  config accepted when cfg_valid && cfg_ready at a rising edge.
REQ-009 cfg_num  in  CNT_W  requested divide ratio.
REQ-010 cfg_duty  in  CNT_W  requested high cycles per period.
REQ-011 div_sig  out  1  registered divided waveform.
REQ-012 period_sig  out  1  one-cycle pulse on last cycle of each period.
REQ-013 busy_sig  out  1  high whenever state != IDLE.
REQ-014 err_sig  out  1  one-cycle pulse on rejected config.

Function
REQ-015 Active settings num_act/duty_act; counter cnt in 0..num_act-1, increments each cycle in RUN/PEND and wraps to 0 after num_act-1.
REQ-016 In RUN/PEND, div_sig == (cnt < duty_act) every cycle; both registered, no combinational output path.
REQ-017 period_sig high exactly on cycles where state is RUN/PEND and cnt == num_act-1.
REQ-018 States IDLE, RUN, PEND; cfg_ready = 1 in IDLE and RUN, 0 in PEND.
REQ-019 IDLE: cnt = 0, div_sig = 0; accepted config loads active settings at the same edge.
REQ-020 IDLE -> RUN when en_sig = 1; first RUN cycle has cnt = 0, div_sig = 1.
REQ-021 en_sig and accepted config in the same IDLE cycle: new settings govern the first period.
REQ-022 RUN -> PEND on accepted valid config; values held in shadow registers.
REQ-023 PEND -> RUN at wrap: shadow loaded, next cycle cnt = 0 under new settings; no truncated or stretched period.
REQ-024 Config accepted on a wrap cycle in RUN applies at the following wrap, not the current one.
REQ-025 en_sig deasserted in RUN/PEND: current period completes, then IDLE at wrap; pending shadow loaded at that wrap.
REQ-026 en_sig reasserted before the wrap cancels the stop; operation continues seamlessly.

Reset
REQ-027 rst_sig low: immediately state IDLE, cnt 0, div_sig 0, period_sig 0, busy_sig 0, err_sig 0, cfg_ready 1, num_act = DEF_NUM, duty_act = DEF_DUTY, shadow discarded.
REQ-028 Reset asserted mid-operation aborts the period and any pending config with no further output activity.

Configuration
REQ-029 Macro DIV_CTRL_ERR_EN defined: config valid only if cfg_num >= 2 and 1 <= cfg_duty <= cfg_num-1; an invalid one is accepted by handshake, err_sig pulses next cycle, active settings and state unchanged.
REQ-030 Macro undefined: no range check, err_sig tied 0, values loaded as given; num <= 1 wraps every cycle (cnt stays 0, period_sig constant high).

Structure
REQ-031 Package div_pkg holds the state enum typedef and CNT_W default constant.
REQ-032 Sub-module div_core holds cnt, compare and wrap detect; div_ctrl holds FSM, handshake, shadow and check.

Verification
REQ-033 Defaults, en_sig = 1: div_sig 1,0,1,0...; period_sig high on every second cycle; busy_sig 1.
REQ-034 RUN at 2/1, cfg 5/2 at cnt = 0: cfg_ready low until wrap; then div_sig 1,1,0,0,0 repeating.
REQ-035 DIV_CTRL_ERR_EN, cfg 1/1 in RUN: err_sig single pulse, waveform unchanged, cfg_ready stays 1.
REQ-036 RUN at 5/2, en_sig low at cnt = 1: runs through cnt = 4, then IDLE, div_sig 0, busy_sig 0.
REQ-037 rst_sig low during PEND: all outputs at reset values without a clock edge; after release with en_sig = 1, waveform uses 2/1.
REQ-038 IDLE, cfg 3/1 with en_sig = 1 same cycle: div_sig 1,0,0 repeating from first RUN cycle.
